// File: rtl/aes_pkg.sv
// aes_pkg: shared widths and launch FSM encoding for the AES ciphertext input path
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W = 32;
  localparam int WORDS_PER_BLOCK = 4;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT_START, WAIT_DONE} launch_state_t;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs 32-bit words into 128-bit blocks through a fill and a hold register
// ports: word_in/word_valid/word_ready stream in, flush drops the partial block,
// hold_clr releases the hold register, hold_full/hold_data present the packed block
module word_packer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_WORD_W-1:0]  word_in,
  input  logic                   word_valid,
  input  logic                   flush,
  input  logic                   hold_clr,
  output logic                   word_ready,
  output logic                   hold_full,
  output logic [AES_BLOCK_W-1:0] hold_data
);
  localparam int CW = $clog2(WORDS_PER_BLOCK);
  localparam int FILL_W = AES_BLOCK_W - AES_WORD_W;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [AES_BLOCK_W-1:0] hold_q, hold_d;
  logic hold_full_q, hold_full_d, xfer, last;
  assign word_ready = (cnt_q != CW'(WORDS_PER_BLOCK - 1)) || !hold_full_q;
  assign xfer = word_valid && word_ready && !flush;
  assign last = xfer && (cnt_q == CW'(WORDS_PER_BLOCK - 1));
  // Words arrive in slot order, so shifting left lands slot 0 in the top bits;
  // stale bits left by a flush are overwritten before the block completes.
  always_comb begin
    cnt_d = flush ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
    fill_d = xfer ? {fill_q[FILL_W-AES_WORD_W-1:0], word_in} : fill_q;
    hold_d = last ? {fill_q, word_in} : hold_q;
    hold_full_d = last || (hold_full_q && !hold_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      fill_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
  assign hold_full = hold_full_q;
  assign hold_data = hold_q;
endmodule

// File: rtl/dec_input_packer.sv
// dec_input_packer: feeds packed ciphertext blocks and a key into DecryptionBlock
// ports: word stream in (word_in/word_valid/word_ready/flush), key_load/key_in,
// data_out/key_out/enable_decrypt to the decryptor, dec_busy back, blk_done/err status
module dec_input_packer
  import aes_pkg::*;
#(
  parameter int START_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_WORD_W-1:0]  word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  input  logic                   flush,
  input  logic                   key_load,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic [AES_BLOCK_W-1:0] data_out,
  output logic [AES_BLOCK_W-1:0] key_out,
  output logic                   enable_decrypt,
  input  logic                   dec_busy,
  output logic                   blk_done,
  output logic                   err
);
  launch_state_t state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic en_q, en_d, done_q, done_d, err_q, err_d, hold_clr, hold_full;
  word_packer u_pack (
    .clk(clk),
    .rst(rst),
    .word_in(word_in),
    .word_valid(word_valid),
    .flush(flush),
    .hold_clr(hold_clr),
    .word_ready(word_ready),
    .hold_full(hold_full),
    .hold_data(data_out)
  );
  // Timeouts compare against N-1 so err is visible exactly N cycles after state entry.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == 8'hff) ? timer_q : timer_q + 8'd1;
    en_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    hold_clr = 1'b0;
    key_d = (key_load && state_q == IDLE && !hold_full) ? key_in : key_q;
    case (state_q)
      IDLE: if (hold_full) begin
        state_d = PULSE;
        en_d = 1'b1;
      end
      PULSE: begin
        state_d = WAIT_START;
        timer_d = '0;
      end
      WAIT_START: if (dec_busy) begin
        state_d = WAIT_DONE;
        timer_d = '0;
      end else if (timer_q >= 8'(START_TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d = 1'b1;
        hold_clr = 1'b1;
      end
      WAIT_DONE: if (!dec_busy) begin
        state_d = IDLE;
        done_d = 1'b1;
        hold_clr = 1'b1;
      end else if (timer_q >= 8'(DONE_TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d = 1'b1;
        hold_clr = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      key_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      key_q <= key_d;
      en_q <= en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign key_out = key_q;
  assign enable_decrypt = en_q;
  assign blk_done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_dec_input_packer.sv
// tb_dec_input_packer: directed checks of packing, launch timing, key gating, timeouts and reset
module tb_dec_input_packer;
  logic clk = 1'b0;
  logic rst, word_valid, word_ready, flush, key_load, enable_decrypt, dec_busy, blk_done, err;
  logic [31:0] word_in;
  logic [127:0] key_in, data_out, key_out;
  always #5 clk = ~clk;
  dec_input_packer dut (
    .clk(clk),
    .rst(rst),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .flush(flush),
    .key_load(key_load),
    .key_in(key_in),
    .data_out(data_out),
    .key_out(key_out),
    .enable_decrypt(enable_decrypt),
    .dec_busy(dec_busy),
    .blk_done(blk_done),
    .err(err)
  );
  int checks = 0, errors = 0;
  int cyc = 0, en_cnt = 0, done_cnt = 0, en_cyc = 0, done_cyc = 0, err_cyc = 0, fall_cyc = 0, xfer_cyc = 0;
  int bcnt = 0, busy_len = 70;
  logic hang = 1'b0, err_seen = 1'b0, busy_prev = 1'b0;
  logic [127:0] en_data = '0;
  always @(posedge clk) begin
    #1;
    if (rst) bcnt = 0;
    dec_busy = hang || (bcnt != 0);
    if (bcnt != 0) bcnt--;
    if (enable_decrypt && busy_len != 0) bcnt = busy_len;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (enable_decrypt) begin
      en_cnt++;
      en_cyc = cyc;
      en_data = data_out;
    end
    if (blk_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err && !err_seen) begin
      err_seen = 1'b1;
      err_cyc = cyc;
    end
    if (busy_prev && !dec_busy) fall_cyc = cyc;
    busy_prev = dec_busy;
  endtask
  task automatic push(input logic [31:0] w);
    int n = 0;
    word_in = w;
    word_valid = 1'b1;
    while (!word_ready && n < 300) begin
      tick();
      n++;
    end
    if (!word_ready) chk("push_timeout", 128'(word_ready), 128'(1));
    tick();
    xfer_cyc = cyc - 1;
    word_valid = 1'b0;
  endtask
  task automatic push4(input logic [127:0] b);
    push(b[127:96]);
    push(b[95:64]);
    push(b[63:32]);
    push(b[31:0]);
  endtask
  task automatic wait_en(input int lim, input string tag);
    int e = en_cnt;
    int n = 0;
    while (en_cnt == e && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_en_seen"}, 128'(en_cnt != e), 128'(1));
  endtask
  task automatic wait_done(input int lim, input string tag);
    int d = done_cnt;
    int n = 0;
    while (done_cnt == d && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done_cnt != d), 128'(1));
  endtask
  task automatic wait_err(input int lim, input string tag);
    int n = 0;
    while (!err_seen && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_err_seen"}, 128'(err_seen), 128'(1));
  endtask
  localparam logic [127:0] K1 = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] D1 = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
  localparam logic [127:0] BA = 128'h11111111222222223333333344444444;
  localparam logic [127:0] BB = 128'ha5a5a5a50f0f0f0f123456789abcdef0;
  localparam logic [127:0] BN = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] B4 = 128'hc0ffee00c0ffee01c0ffee02c0ffee03;
  localparam logic [127:0] B5 = 128'h600d0000600d0001600d0002600d0003;
  localparam logic [127:0] B6 = 128'h8badf00d8badf00e8badf00f8badf010;
  localparam logic [127:0] BF = 128'h13579bdf2468ace0fedcba9876543210;
  initial begin
    int e0, d0, n;
    logic bad;
    rst = 1'b1;
    word_valid = 1'b0;
    flush = 1'b0;
    key_load = 1'b0;
    word_in = '0;
    key_in = '0;
    tick();
    tick();
    chk("rst_data", data_out, '0);
    chk("rst_key", key_out, '0);
    chk("rst_en", 128'(enable_decrypt), 128'(0));
    chk("rst_done", 128'(blk_done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_ready", 128'(word_ready), 128'(1));
    rst = 1'b0;
    // basic block
    key_in = K1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t1_key", key_out, K1);
    e0 = en_cnt;
    d0 = done_cnt;
    push4(D1);
    chk("t1_data", data_out, D1);
    wait_en(10, "t1");
    chk("t1_en_lat", 128'(en_cyc - xfer_cyc), 128'(2));
    wait_done(200, "t1");
    chk("t1_done_lat", 128'(done_cyc - en_cyc), 128'(72));
    chk("t1_done_after_fall", 128'(done_cyc - fall_cyc), 128'(1));
    tick();
    chk("t1_done_one_cycle", 128'(blk_done), 128'(0));
    chk("t1_en_count", 128'(en_cnt - e0), 128'(1));
    chk("t1_done_count", 128'(done_cnt - d0), 128'(1));
    chk("t1_key_hold", key_out, K1);
    // back-to-back blocks
    push4(BA);
    push(BB[127:96]);
    push(BB[95:64]);
    push(BB[63:32]);
    chk("t2_launch_a", en_data, BA);
    word_in = BB[31:0];
    word_valid = 1'b1;
    chk("t2_ready_low", 128'(word_ready), 128'(0));
    bad = 1'b0;
    n = 0;
    while (!word_ready && n < 300) begin
      if (data_out !== BA) bad = 1'b1;
      tick();
      n++;
    end
    chk("t2_hold_stable", 128'(bad), 128'(0));
    chk("t2_release_data", data_out, BA);
    chk("t2_released_by_done", 128'(blk_done), 128'(1));
    tick();
    word_valid = 1'b0;
    wait_en(10, "t2");
    chk("t2_b_lat", 128'(en_cyc - done_cyc), 128'(2));
    chk("t2_launch_b", en_data, BB);
    wait_done(200, "t2");
    // flush drops the partial block and a coincident word
    push(32'hdead0001);
    push(32'hdead0002);
    word_in = 32'hffffffff;
    word_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    word_valid = 1'b0;
    push4(BN);
    wait_en(10, "t3");
    chk("t3_en_lat", 128'(en_cyc - xfer_cyc), 128'(2));
    chk("t3_launch", en_data, BN);
    wait_done(200, "t3");
    // key_load gating
    push4(B4);
    wait_en(10, "t4");
    tick();
    tick();
    tick();
    key_in = K2;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t4_key_ignored", key_out, K1);
    wait_done(200, "t4");
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t4_key_loaded", key_out, K2);
    // start timeout
    busy_len = 0;
    d0 = done_cnt;
    push4(B5);
    wait_en(10, "t5");
    wait_err(50, "t5");
    chk("t5_err_lat", 128'(err_cyc - en_cyc), 128'(9));
    tick();
    chk("t5_no_done", 128'(done_cnt - d0), 128'(0));
    busy_len = 70;
    push4(BN);
    wait_en(10, "t5b");
    chk("t5_idle_lat", 128'(en_cyc - xfer_cyc), 128'(2));
    wait_done(200, "t5b");
    chk("t5_err_sticky", 128'(err), 128'(1));
    // done timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_seen = 1'b0;
    chk("t5_err_cleared", 128'(err), 128'(0));
    busy_len = 0;
    hang = 1'b1;
    d0 = done_cnt;
    push4(B5);
    wait_en(10, "t5c");
    wait_err(200, "t5c");
    chk("t5_done_to_lat", 128'(err_cyc - en_cyc), 128'(130));
    hang = 1'b0;
    busy_len = 70;
    tick();
    tick();
    chk("t5c_no_done", 128'(done_cnt - d0), 128'(0));
    // reset mid-operation
    key_in = K3;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t6_key", key_out, K3);
    push4(B6);
    wait_en(10, "t6");
    push(32'h0badbad1);
    push(32'h0badbad2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_data", data_out, '0);
    chk("t6_rst_key", key_out, '0);
    chk("t6_rst_en", 128'(enable_decrypt), 128'(0));
    chk("t6_rst_done", 128'(blk_done), 128'(0));
    chk("t6_rst_err", 128'(err), 128'(0));
    chk("t6_rst_ready", 128'(word_ready), 128'(1));
    rst = 1'b0;
    err_seen = 1'b0;
    push4(BF);
    wait_en(10, "t6b");
    chk("t6_en_lat", 128'(en_cyc - xfer_cyc), 128'(2));
    chk("t6_launch", en_data, BF);
    wait_done(200, "t6b");
    chk("t6_done_lat", 128'(done_cyc - en_cyc), 128'(72));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_input_packer.md
Name: dec_input_packer

Overview:
- Upstream feeder for DecryptionBlock.
- Packs a 32-bit ciphertext word stream from the SD read path into 128-bit AES blocks and holds a 128-bit key.
- Launches each block into DecryptionBlock with a one-cycle enable_decrypt pulse, then tracks dec_busy until the block is consumed.
- Double-buffered: one fill register and one hold register, so the next block streams in while the current one decrypts.

Parameters:
- START_TIMEOUT, 8: max cycles after the enable pulse for dec_busy to rise.
- DONE_TIMEOUT, 128: max cycles dec_busy may stay high.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- word_in  in  32  ciphertext word; first word of a block = bits 127:96.
- word_valid  in  1  word_in valid.
- word_ready  out  1  packer accepts word_in this cycle.
- flush  in  1  discard the partially filled block.
- key_load  in  1  latch key_in.
- key_in  in  128  AES-128 key.
- data_out  out  128  block to DecryptionBlock.data_in.
- key_out  out  128  key to DecryptionBlock.key_in.
- enable_decrypt  out  1  one-cycle launch pulse.
- dec_busy  in  1  from DecryptionBlock.
- blk_done  out  1  one-cycle pulse when a launched block finishes.
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset values:
  - Outputs: data_out=0, key_out=0, enable_decrypt=0, blk_done=0, err=0.
  - Internal: word count=0, hold_full=0, FSM=IDLE.
  - word_ready=1 out of reset.
- Fill path:
  - A word transfers when word_valid && word_ready.
  - The word goes to slot cnt (slot 0 = [127:96] … slot 3 = [31:0]); cnt increments mod 4.
- Hold transfer:
  - On the 4th transfer, the fill register plus the new word copy into the hold register next edge; hold_full=1.
  - data_out is driven from the hold register.
- word_ready = (cnt != 3) || !hold_full.
  - This is a registered-state function, combinational to the output.
  - A hold release in the same cycle does not raise word_ready.
- flush:
  - Sets cnt=0 next cycle; the hold register is untouched.
  - If flush and a word transfer coincide, flush wins and the word is dropped.
- key_load:
  - Updates key_out only when FSM=IDLE and hold_full=0.
  - Otherwise the load is ignored; key_out never changes while a block is pending or in flight.
- FSM states: IDLE, PULSE, WAIT_START, WAIT_DONE.
  - IDLE: if hold_full → PULSE.
  - PULSE: enable_decrypt=1 for exactly this cycle; timer cleared → WAIT_START.
  - WAIT_START: if dec_busy → WAIT_DONE with timer cleared. If the timer reaches START_TIMEOUT → err=1, hold_full=0, → IDLE, no blk_done.
  - WAIT_DONE: if !dec_busy → blk_done=1 for one cycle, hold_full=0, → IDLE. If the timer reaches DONE_TIMEOUT → err=1, hold_full=0, → IDLE, no blk_done.
- Latency and throughput:
  - Minimum from hold_full=1 to enable_decrypt is 1 cycle (the IDLE→PULSE edge).
  - After release, the next held block pulses 2 cycles later (IDLE, then PULSE).
- Stability: data_out and key_out are constant from the PULSE cycle through the release cycle.
- Fill during decrypt:
  - The fill register keeps accepting while the FSM is busy.
  - A completed block waits, with word_ready=0 at cnt=3, until hold_full=0.
  - Hold release and the 4th word transfer in the same cycle: the transfer cannot occur (word_ready=0), so there is no conflict.
- Timer: 8 bits, saturating.
- rst mid-operation: everything returns to reset values next edge. enable_decrypt is never held across reset.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128, AES_WORD_W=32, WORDS_PER_BLOCK=4.
  - Enum launch_state_t {IDLE, PULSE, WAIT_START, WAIT_DONE}.
- One sub-module, word_packer: fill register, word counter, flush, word_ready and hold-register logic.
- The top level holds the key register, launch FSM and timers.

Test Plan:
- Reset, then key_load key_in=128'h5e74e7ba66b0c7cc1b7697b3f9f51527, then push words deb0f813, 41f3503a, 7cd01e2b, c7cdd556.
  - Expect data_out=128'hdeb0f81341f3503a7cd01e2bc7cdd556 and key_out equal to the loaded key.
  - Expect one enable_decrypt pulse 2 cycles after the 4th word.
  - Model dec_busy high 70 cycles: blk_done pulses once on the cycle after dec_busy falls.
- Push 8 words back-to-back with dec_busy held for 70 cycles.
  - word_ready drops at cnt=3 of block 2.
  - Block 2 launches exactly 2 cycles after blk_done of block 1.
  - data_out is unchanged during block 1.
- Push 2 words, assert flush, push 4 new words.
  - The launched block contains only the 4 new words; the first 2 are gone.
- key_load with a new key while in WAIT_DONE → key_out unchanged.
  - The same key_load after blk_done → key_out updates next cycle.
- Never raise dec_busy → err=1 exactly START_TIMEOUT cycles after WAIT_START entry; no blk_done; FSM returns to IDLE.
  - Variant: hold dec_busy high forever → err after DONE_TIMEOUT.
- Assert rst during WAIT_DONE with a partial fill of 2 words.
  - Next cycle all outputs are at reset values and cnt=0.
  - A fresh 4-word block then launches normally.
